// File: rtl/stc0_pkg.sv
// Shared types and helpers for the stc0 pad link: serializer state encoding,
// beat-count derivation and a saturating counter increment.
package stc0_pkg;

    typedef logic [0:0] ser_state_t;
    localparam ser_state_t SER_IDLE = 1'b0;
    localparam ser_state_t SER_SEND = 1'b1;

    function automatic int unsigned beats(input int unsigned word_w, input int unsigned pad_w);
        return word_w / pad_w;
    endfunction

    // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] top_v;
        top_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= top_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/stc0_pad_link_if.sv
// Pad-side and core-side signal bundle of stc0_pad_link.
// IPar/EPar/ParCnt exist only when STC0_PAD_PARITY_EN is defined.
interface stc0_pad_link_if #(
    parameter int unsigned PAD_W  = 8,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic [PAD_W-1:0]  ID;
    logic              IValid;
    logic              ISof;
    logic [WORD_W-1:0] IngData;
    logic              IngValid;
    logic              IngReady;
    logic [WORD_W-1:0] EgData;
    logic              EgValid;
    logic              EgReady;
    logic [PAD_W-1:0]  ED;
    logic              EValid;
    logic              ESof;
    logic              ERdy;
    logic              LoopEn;
    logic              ClrCnt;
    logic [CNT_W-1:0]  DropCnt;
    logic [CNT_W-1:0]  AlignCnt;
`ifdef STC0_PAD_PARITY_EN
    logic              IPar;
    logic              EPar;
    logic [CNT_W-1:0]  ParCnt;
`endif

    modport slave (
        input  ID, IValid, ISof, IngReady, EgData, EgValid, ERdy, LoopEn, ClrCnt,
`ifdef STC0_PAD_PARITY_EN
        input  IPar,
        output EPar, ParCnt,
`endif
        output IngData, IngValid, EgReady, ED, EValid, ESof, DropCnt, AlignCnt
    );

    modport master (
        output ID, IValid, ISof, IngReady, EgData, EgValid, ERdy, LoopEn, ClrCnt,
`ifdef STC0_PAD_PARITY_EN
        output IPar,
        input  EPar, ParCnt,
`endif
        input  IngData, IngValid, EgReady, ED, EValid, ESof, DropCnt, AlignCnt
    );

endinterface

// File: rtl/stc0_sync_fifo.sv
// First-word fall-through FIFO: pop_data shows the head whenever !empty.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module stc0_sync_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic         ClkProc,
    input  logic         ARst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         empty,
    output logic         full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign pop_data = mem[rd_ptr_q];

    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge ClkProc or posedge ARst) begin
        if (ARst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset; stale contents are never visible while empty.
    always_ff @(posedge ClkProc) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/stc0_pad_link.sv
// Pad-side link for stc0: beat deserialiser + FWFT FIFO on ingress, IDLE/SEND
// serializer on egress, optional loopback. Parity option: STC0_PAD_PARITY_EN.
module stc0_pad_link
    import stc0_pkg::*;
#(
    parameter int unsigned PAD_W  = 8,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic            ClkProc,
    input  logic            ARst,
    stc0_pad_link_if.slave  bus
);
    localparam int unsigned BEATS = beats(WORD_W, PAD_W);
    localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    genvar gi;

    // Ingress assembly
    logic              inprog_q, inprog_d;
    logic [BCW-1:0]    ibeat_q, ibeat_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic              ing_start, ing_cont, ing_stray, ing_wr, ing_last, ing_push;
    logic [BCW-1:0]    ing_lane;
    logic              word_bad;
`ifdef STC0_PAD_PARITY_EN
    logic              bad_q, bad_d;
    logic              beat_bad;
    logic [CNT_W-1:0]  par_q, par_d;
`endif

    // FIFO and counters
    logic [WORD_W-1:0] fifo_data;
    logic              fifo_empty, fifo_full, fifo_pop, fifo_valid;
    logic [CNT_W-1:0]  drop_q, drop_d, align_q, align_d;
    logic              drop_inc, align_inc;

    // Egress serializer
    ser_state_t        state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [BCW-1:0]    ebeat_q, ebeat_d;
    logic              loop_q, loop_d;
    logic              run_q;
    logic              last_beat, load_pt, sel_loop, src_valid, load, sending;
    logic [WORD_W-1:0] src_data;
    logic              ing_valid;
    logic [PAD_W-1:0]  ed_w;
    logic [PAD_W-1:0]  eg_lane [BEATS];

    always_comb begin
        ing_start = bus.IValid & bus.ISof;
        ing_cont  = bus.IValid & ~bus.ISof & inprog_q;
        ing_stray = bus.IValid & ~bus.ISof & ~inprog_q;
        ing_wr    = ing_start | ing_cont;
        ing_lane  = ing_start ? '0 : ibeat_q;
        ing_last  = ing_wr & (ing_lane == LAST_BEAT);
        ibeat_d   = ibeat_q;
        inprog_d  = inprog_q;
        if (ing_wr) begin
            ibeat_d  = ing_last ? '0 : ing_lane + 1'b1;
            inprog_d = ~ing_last;
        end
`ifdef STC0_PAD_PARITY_EN
        beat_bad = bus.IPar ^ (^bus.ID);
        bad_d    = bad_q;
        if (ing_wr) begin
            bad_d = (ing_start ? 1'b0 : bad_q) | beat_bad;
        end
        word_bad = ing_last & bad_d;
`else
        word_bad = 1'b0;
`endif
        ing_push  = ing_last & ~word_bad;
        // A fresh ISof abandons any partial word; a headless beat is discarded.
        align_inc = (ing_start & inprog_q) | ing_stray;
        drop_inc  = ing_push & fifo_full & ~fifo_pop;
    end

    // Little-endian lanes: beat k of a word lands at bits [k*PAD_W +: PAD_W].
    for (gi = 0; gi < BEATS; gi++) begin : g_ing_lane
        assign asm_d[gi*PAD_W +: PAD_W] = (ing_wr && ing_lane == BCW'(gi)) ?
                                          bus.ID : asm_q[gi*PAD_W +: PAD_W];
    end

    stc0_sync_fifo #(
        .W     (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .ClkProc   (ClkProc),
        .ARst      (ARst),
        .push      (ing_push),
        .push_data (asm_d),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        drop_d  = bus.ClrCnt ? '0 : (drop_inc  ? CNT_W'(sat_inc(32'(drop_q),  CNT_W)) : drop_q);
        align_d = bus.ClrCnt ? '0 : (align_inc ? CNT_W'(sat_inc(32'(align_q), CNT_W)) : align_q);
`ifdef STC0_PAD_PARITY_EN
        par_d   = bus.ClrCnt ? '0 : (word_bad  ? CNT_W'(sat_inc(32'(par_q),   CNT_W)) : par_q);
`endif
    end

    // Word boundaries (IDLE, or last beat being accepted) are the only points
    // where the source is chosen; the chosen mode then sticks for the word.
    always_comb begin
        sending   = (state_q == SER_SEND);
        last_beat = (ebeat_q == LAST_BEAT);
        load_pt   = (~sending & run_q) | (sending & last_beat & bus.ERdy);
        sel_loop  = load_pt ? bus.LoopEn : loop_q;
        fifo_valid = ~fifo_empty;
        ing_valid = fifo_valid & ~sel_loop;
        src_valid = sel_loop ? fifo_valid : bus.EgValid;
        src_data  = sel_loop ? fifo_data  : bus.EgData;
        load      = load_pt & src_valid;
        fifo_pop  = sel_loop ? (load & fifo_valid) : (ing_valid & bus.IngReady);

        state_d = state_q;
        word_d  = word_q;
        ebeat_d = ebeat_q;
        loop_d  = loop_q;
        if (load) begin
            state_d = SER_SEND;
            word_d  = src_data;
            ebeat_d = '0;
            loop_d  = sel_loop;
        end else if (sending && bus.ERdy) begin
            if (last_beat) begin
                state_d = SER_IDLE;
            end else begin
                ebeat_d = ebeat_q + 1'b1;
            end
        end
    end

    for (gi = 0; gi < BEATS; gi++) begin : g_eg_lane
        assign eg_lane[gi] = word_q[gi*PAD_W +: PAD_W];
    end

    assign ed_w         = sending ? eg_lane[ebeat_q] : '0;
    assign bus.ED       = ed_w;
    assign bus.EValid   = sending;
    assign bus.ESof     = sending & (ebeat_q == '0);
    assign bus.EgReady  = load_pt & ~sel_loop;
    assign bus.IngValid = ing_valid;
    assign bus.IngData  = ing_valid ? fifo_data : '0;
    assign bus.DropCnt  = drop_q;
    assign bus.AlignCnt = align_q;
`ifdef STC0_PAD_PARITY_EN
    assign bus.EPar     = ^ed_w;
    assign bus.ParCnt   = par_q;
`endif

    // run_q keeps EgReady low until the first edge after reset release.
    always_ff @(posedge ClkProc or posedge ARst) begin
        if (ARst) begin
            inprog_q <= 1'b0;
            ibeat_q  <= '0;
            asm_q    <= '0;
            drop_q   <= '0;
            align_q  <= '0;
            state_q  <= SER_IDLE;
            word_q   <= '0;
            ebeat_q  <= '0;
            loop_q   <= 1'b0;
            run_q    <= 1'b0;
`ifdef STC0_PAD_PARITY_EN
            bad_q    <= 1'b0;
            par_q    <= '0;
`endif
        end else begin
            inprog_q <= inprog_d;
            ibeat_q  <= ibeat_d;
            asm_q    <= asm_d;
            drop_q   <= drop_d;
            align_q  <= align_d;
            state_q  <= state_d;
            word_q   <= word_d;
            ebeat_q  <= ebeat_d;
            loop_q   <= loop_d;
            run_q    <= 1'b1;
`ifdef STC0_PAD_PARITY_EN
            bad_q    <= bad_d;
            par_q    <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_stc0_pad_link.sv
// Directed + randomized bench for stc0_pad_link (PAD_W=8, WORD_W=32, DEPTH=8,
// CNT_W=4) against a queue-based model of words, FIFO and counters.
module tb_stc0_pad_link;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int          m_k = 0;
    logic [31:0] m_word = '0;
    bit          m_bad = 0;
    logic [31:0] m_fifo[$];
    int          m_drop = 0;
    int          m_align = 0;
    int          m_par = 0;

    stc0_pad_link_if #(.PAD_W(8), .WORD_W(32), .CNT_W(4)) bus ();

    stc0_pad_link #(
        .PAD_W  (8),
        .WORD_W (32),
        .DEPTH  (8),
        .CNT_W  (4)
    ) dut (
        .ClkProc (clk),
        .ARst    (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ingvalid"}, 64'(bus.IngValid), 64'(0));
        chk({tag, "_ingdata"},  64'(bus.IngData),  64'(0));
        chk({tag, "_evalid"},   64'(bus.EValid),   64'(0));
        chk({tag, "_ed"},       64'(bus.ED),       64'(0));
        chk({tag, "_esof"},     64'(bus.ESof),     64'(0));
        chk({tag, "_egready"},  64'(bus.EgReady),  64'(0));
        chk({tag, "_dropcnt"},  64'(bus.DropCnt),  64'(0));
        chk({tag, "_aligncnt"}, 64'(bus.AlignCnt), 64'(0));
    endtask

    task automatic model_reset();
        m_k = 0; m_bad = 0; m_word = '0;
        m_fifo.delete();
        m_drop = 0; m_align = 0; m_par = 0;
    endtask

    // One ingress cycle: drive, advance the model by the word-level rules, clock, check.
    task automatic ibeat(input bit v, input bit sof, input logic [7:0] id,
                         input bit rdy, input bit parok, input bit clr);
        bit bb;
        bit done;
        bb = !parok;
`ifndef STC0_PAD_PARITY_EN
        bb = 1'b0;
`endif
        bus.IValid = v; bus.ISof = sof; bus.ID = id;
        bus.IngReady = rdy; bus.ClrCnt = clr;
`ifdef STC0_PAD_PARITY_EN
        bus.IPar = parok ? ^id : ~^id;
`endif
        done = 0;
        if (v) begin
            if (sof) begin
                if (m_k > 0) m_align++;
                m_word = '0; m_word[7:0] = id; m_k = 1; m_bad = bb;
            end else if (m_k == 0) begin
                m_align++;
            end else begin
                m_word[m_k*8 +: 8] = id; m_bad = m_bad | bb; m_k++;
            end
            if (m_k == 4) begin done = 1; m_k = 0; end
        end
        if (rdy && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (done) begin
            if (m_bad) begin
                m_par++;
                $display("ingress word %08h parity-reject", m_word);
            end else if (m_fifo.size() < 8) begin
                m_fifo.push_back(m_word);
                $display("ingress word %08h queued", m_word);
            end else begin
                m_drop++;
                $display("ingress word %08h dropped", m_word);
            end
        end
        if (clr) begin m_drop = 0; m_align = 0; m_par = 0; end
        @(posedge clk); #1;
        chk("ing_valid", 64'(bus.IngValid), 64'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) chk("ing_data", 64'(bus.IngData), 64'(m_fifo[0]));
        chk("drop_cnt",  64'(bus.DropCnt),  64'(sat4(m_drop)));
        chk("align_cnt", 64'(bus.AlignCnt), 64'(sat4(m_align)));
`ifdef STC0_PAD_PARITY_EN
        chk("par_cnt",   64'(bus.ParCnt),   64'(sat4(m_par)));
`endif
    endtask

    task automatic ing_word(input logic [31:0] w, input bit [3:0] rdy,
                            input int badbeat, input bit clr_last);
        for (int b = 0; b < 4; b++)
            ibeat(1'b1, b == 0, w[b*8 +: 8], rdy[b], b != badbeat, clr_last && b == 3);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) ibeat(1'b0, 1'b0, 8'h00, rdy, 1'b1, 1'b0);
    endtask

    // Stream words out with the bench acting as core source and pad partner.
    task automatic run_egress(input logic [31:0] words[$], input bit toggle);
        logic [7:0]  eq[$];
        logic [31:0] src[$];
        logic [7:0]  held_ed;
        bit held, started, exp_rdy;
        int bidx, cyc;
        held = 0; started = 0; bidx = 0; cyc = 0; held_ed = '0;
        src = words;
        foreach (words[i]) for (int b = 0; b < 4; b++) eq.push_back(words[i][b*8 +: 8]);
        bus.IValid = 1'b0; bus.LoopEn = 1'b0; bus.ClrCnt = 1'b0;
        while ((eq.size() > 0 || src.size() > 0) && cyc < 400) begin
            bus.ERdy = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (held) begin
                chk("eg_hold_valid", 64'(bus.EValid), 64'(1));
                chk("eg_hold_ed", 64'(bus.ED), 64'(held_ed));
                held = 0;
            end
            if (bus.EValid) begin
                started = 1;
                exp_rdy = (bidx % 4 == 3) && bus.ERdy;
                chk("eg_sof", 64'(bus.ESof), 64'(bidx % 4 == 0));
                if (bus.ERdy) begin
                    chk("eg_ed", 64'(bus.ED), 64'(eq[0]));
`ifdef STC0_PAD_PARITY_EN
                    chk("eg_par", 64'(bus.EPar), 64'(^eq[0]));
`endif
                    if (bidx % 4 == 3) $display("egress word %0d sent", bidx / 4);
                    void'(eq.pop_front());
                    bidx++;
                end else begin
                    held = 1; held_ed = bus.ED;
                end
            end else begin
                exp_rdy = 1'b1;
                if (started && !toggle) chk("eg_no_bubble", 64'(bus.EValid), 64'(eq.size() > 0));
            end
            chk("eg_ready", 64'(bus.EgReady), 64'(exp_rdy));
            if (src.size() > 0) begin
                bus.EgValid = 1'b1; bus.EgData = src[0];
                if (bus.EgReady) void'(src.pop_front());
            end else begin
                bus.EgValid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("eg_complete", 64'(eq.size()), 64'(0));
        bus.EgValid = 1'b0;
        chk("eg_idle_after", 64'(bus.EValid), 64'(0));
    endtask

    initial begin
        logic [31:0] wl[$];
        logic [7:0]  lexp[$];
        int          k;

        rst = 1'b1;
        bus.ID = '0; bus.IValid = 0; bus.ISof = 0; bus.IngReady = 0;
        bus.EgData = '0; bus.EgValid = 0; bus.ERdy = 0; bus.LoopEn = 0; bus.ClrCnt = 0;
`ifdef STC0_PAD_PARITY_EN
        bus.IPar = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: single word, fall-through one cycle after the final beat
        $display("step 1: basic ingress");
        ing_word(32'h44332211, 4'b0000, -1, 1'b0);
        chk("t1_word", 64'(bus.IngData), 64'h44332211);
        idle(2, 1'b1);

        // 2: overflow by one, drain in order, then push+pop while full
        $display("step 2: fifo full / drop");
        for (int i = 0; i < 9; i++) ing_word($urandom, 4'b0000, -1, 1'b0);
        chk("t2_drop1", 64'(bus.DropCnt), 64'(1));
        ing_word($urandom, 4'b1000, -1, 1'b0);
        chk("t2_pushpop_full", 64'(bus.DropCnt), 64'(1));
        idle(10, 1'b1);

        // 3: alignment errors
        $display("step 3: alignment");
        ibeat(1'b1, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0);
        ibeat(1'b1, 1'b0, 8'hA1, 1'b0, 1'b1, 1'b0);
        ing_word($urandom, 4'b0000, -1, 1'b0);
        chk("t3_align1", 64'(bus.AlignCnt), 64'(1));
        ibeat(1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0);
        chk("t3_align2", 64'(bus.AlignCnt), 64'(2));
        idle(3, 1'b1);

        // 4: egress back-to-back, then random words with ERdy toggling
        $display("step 4: egress");
        wl = '{32'hA5A50F0F, 32'hDEADBEEF};
        run_egress(wl, 1'b0);
        wl = '{};
        for (int i = 0; i < 4; i++) wl.push_back($urandom);
        run_egress(wl, 1'b1);

        // 5: loopback of one ingress word
        $display("step 5: loopback");
        bus.LoopEn = 1'b1; bus.IngReady = 1'b1; bus.ERdy = 1'b1; bus.EgValid = 1'b0;
        lexp = '{8'h11, 8'h22, 8'h33, 8'h44};
        k = 0;
        for (int i = 0; i < 14; i++) begin
            bus.IValid = (i < 4); bus.ISof = (i == 0);
            bus.ID = 8'((i + 1) * 8'h11);
`ifdef STC0_PAD_PARITY_EN
            bus.IPar = ^bus.ID;
`endif
            #1;
            chk("lb_ingvalid", 64'(bus.IngValid), 64'(0));
            chk("lb_egready",  64'(bus.EgReady),  64'(0));
            if (bus.EValid && k < 4) begin
                chk("lb_ed", 64'(bus.ED), 64'(lexp[k]));
                chk("lb_sof", 64'(bus.ESof), 64'(k == 0));
                k++;
            end
            @(posedge clk); #1;
        end
        chk("lb_beats", 64'(k), 64'(4));
        bus.LoopEn = 1'b0; bus.IValid = 1'b0;
        idle(2, 1'b1);

        // 6a: reset with a partial ingress word and an egress word in flight
        $display("step 6: reset mid-word");
        ibeat(1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
        ibeat(1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0);
        bus.IValid = 1'b0; bus.EgValid = 1'b1; bus.EgData = $urandom; bus.ERdy = 1'b1;
        @(posedge clk); #1;
        bus.EgValid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_evalid", 64'(bus.EValid), 64'(1));
        rst = 1'b1;
        #1;
        chk_zero("mid_rst");
        @(posedge clk); #3;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        ing_word($urandom, 4'b0000, -1, 1'b0);
        idle(2, 1'b1);
        wl = '{$urandom};
        run_egress(wl, 1'b0);

        // 6b: saturation, then ClrCnt on the same edge as a drop
        for (int i = 0; i < 28; i++) ing_word($urandom, 4'b0000, -1, 1'b0);
        chk("t6_sat", 64'(bus.DropCnt), 64'(15));
        ing_word($urandom, 4'b0000, -1, 1'b1);
        chk("t6_clr", 64'(bus.DropCnt), 64'(0));
        idle(10, 1'b1);

`ifdef STC0_PAD_PARITY_EN
        ing_word($urandom, 4'b0000, 2, 1'b0);
        chk("t6_par", 64'(bus.ParCnt), 64'(1));
        chk("t6_par_nopush", 64'(bus.IngValid), 64'(0));
        idle(2, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
